// File: rtl/common_ram_prefetcher_if.sv
// Bundles the read-ahead prefetcher's RAM read port, flush request and
// consumer FIFO port.
//   master : prefetcher side (drives the RAM read request and the FIFO head)
//   slave  : environment side (RAM, flush source and consumer)
// Signals:
//   bus_read_vaild/address   request to common_ram
//   bus_read_ready/data      one-cycle response from common_ram
//   flush_valid/address      restart fetching at a new address
//   out_valid/ready          FIFO head handshake with the consumer
//   out_data/address/count   head word, its RAM address, FIFO occupancy
interface common_ram_prefetcher_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    logic                      bus_read_vaild;
    logic                      bus_read_ready;
    logic [ADDR_WIDTH-1:0]     bus_read_address;
    logic [DATA_WIDTH-1:0]     bus_read_data;
    logic                      flush_valid;
    logic [ADDR_WIDTH-1:0]     flush_address;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_data;
    logic [ADDR_WIDTH-1:0]     out_address;
    logic [$clog2(DEPTH):0]    out_count;

    modport master (
        output bus_read_vaild, bus_read_address,
        output out_valid, out_data, out_address, out_count,
        input  bus_read_ready, bus_read_data,
        input  flush_valid, flush_address, out_ready
    );

    modport slave (
        input  bus_read_vaild, bus_read_address,
        input  out_valid, out_data, out_address, out_count,
        output bus_read_ready, bus_read_data,
        output flush_valid, flush_address, out_ready
    );
endinterface

// File: rtl/common_ram_prefetcher.sv
// Sequential read-ahead master for common_ram. Fetches consecutive word
// addresses (from RESET_ADDRESS or a flush target) with at most one read
// outstanding, and buffers {data, address} pairs in a DEPTH-entry FIFO.
// Ports:
//   clock  rising-edge clock
//   reset  synchronous, active-high
//   bus    common_ram_prefetcher_if.master (RAM read port, flush, FIFO out)
module common_ram_prefetcher #(
    parameter int ADDR_WIDTH    = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 4,
    parameter int RESET_ADDRESS = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    common_ram_prefetcher_if.master  bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DRAIN
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fetch_addr_q, fetch_addr_d;
    logic [ADDR_WIDTH-1:0]   drain_addr_q, drain_addr_d;
    logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0]   data_mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0]   addr_mem_q [DEPTH];
    logic                    push;
    logic                    pop;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        drain_addr_d = drain_addr_q;
        push         = 1'b0;
        // Flush outranks a consumer pop in the same cycle.
        pop          = (count_q != '0) && bus.out_ready && !bus.flush_valid;

        unique case (state_q)
            IDLE: begin
                if (bus.flush_valid) begin
                    fetch_addr_d = bus.flush_address;
                    state_d      = REQ;
                end else if (count_q < CW'(DEPTH)) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bus.flush_valid) begin
                    if (bus.bus_read_ready) begin
                        // Arriving word belongs to the old stream: drop it.
                        fetch_addr_d = bus.flush_address;
                        state_d      = REQ;
                    end else begin
                        // Bus address must stay put until the in-flight read
                        // completes, so the target is parked separately.
                        drain_addr_d = bus.flush_address;
                        state_d      = DRAIN;
                    end
                end else if (bus.bus_read_ready) begin
                    push         = 1'b1;
                    fetch_addr_d = fetch_addr_q + 1'b1;
                    if ((count_q + CW'(1) - CW'(pop)) < CW'(DEPTH)) begin
                        state_d = REQ;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DRAIN: begin
                if (bus.flush_valid) begin
                    drain_addr_d = bus.flush_address;
                end
                if (bus.bus_read_ready) begin
                    fetch_addr_d = bus.flush_valid ? bus.flush_address : drain_addr_q;
                    state_d      = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (bus.flush_valid) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            fetch_addr_q <= ADDR_WIDTH'(RESET_ADDRESS);
            drain_addr_q <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            drain_addr_q <= drain_addr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // Storage needs no reset: occupancy gates everything visible.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            data_mem_q[wr_ptr_q] <= bus.bus_read_data;
            addr_mem_q[wr_ptr_q] <= fetch_addr_q;
        end
    end

    assign bus.bus_read_vaild   = (state_q != IDLE);
    assign bus.bus_read_address = fetch_addr_q;
    assign bus.out_valid        = (count_q != '0);
    assign bus.out_count        = count_q;
    assign bus.out_data         = (count_q != '0) ? data_mem_q[rd_ptr_q] : '0;
    assign bus.out_address      = (count_q != '0) ? addr_mem_q[rd_ptr_q] : '0;
endmodule

// File: tb/tb_common_ram_prefetcher.sv
// Bench for common_ram_prefetcher: directed scenarios followed by random
// flush/reset/consumer/RAM-latency traffic, compared each cycle against a
// transaction-level model (expected fetch pointer plus a queue of words).
module tb_common_ram_prefetcher;
    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    common_ram_prefetcher_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

    common_ram_prefetcher #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_ADDRESS(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } word_t;

    word_t           q[$];
    logic [DW-1:0]   ram [1 << AW];
    logic            m_req;
    logic            m_drain;
    logic [AW-1:0]   m_ptr;
    logic [AW-1:0]   m_tgt;
    int unsigned     wait_cnt;
    int unsigned     lat_min;
    int unsigned     lat_max;
    int unsigned     n_checks;
    int unsigned     n_bad;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check_eq("rd_vaild",    64'(bus.bus_read_vaild),   64'(m_req));
        check_eq("rd_address",  64'(bus.bus_read_address), 64'(m_ptr));
        check_eq("out_valid",   64'(bus.out_valid),        64'(q.size() > 0));
        check_eq("out_count",   64'(bus.out_count),        64'(q.size()));
        check_eq("out_data",    64'(bus.out_data),         (q.size() > 0) ? 64'(q[0].d) : 64'h0);
        check_eq("out_address", 64'(bus.out_address),      (q.size() > 0) ? 64'(q[0].a) : 64'h0);
    endtask

    // One clock cycle: check the state left by the previous edge, drive this
    // cycle's inputs, advance the model, move to the next falling edge.
    task automatic step(input logic rst, input logic fl, input logic [AW-1:0] fa,
                        input logic ord, input logic stray);
        logic        rdy;
        logic        prev;
        logic        took;
        int unsigned pre;
        check_outputs();
        rdy = stray || (m_req && wait_cnt == 0);
        reset              = rst;
        bus.flush_valid    = fl;
        bus.flush_address  = fa;
        bus.out_ready      = ord;
        bus.bus_read_ready = rdy;
        bus.bus_read_data  = rdy ? ram[m_ptr] : '0;

        prev = m_req;
        took = m_req && rdy;
        if (rst) begin
            q.delete();
            m_req   = 1'b0;
            m_drain = 1'b0;
            m_ptr   = '0;
        end else if (fl) begin
            q.delete();
            if (m_req && !rdy && !m_drain) begin
                m_drain = 1'b1;
                m_tgt   = fa;
            end else if (m_drain && !rdy) begin
                m_tgt = fa;
            end else begin
                m_req   = 1'b1;
                m_drain = 1'b0;
                m_ptr   = fa;
            end
        end else begin
            pre = q.size();
            if (q.size() > 0 && ord) void'(q.pop_front());
            if (m_req && rdy) begin
                if (m_drain) begin
                    m_drain = 1'b0;
                    m_ptr   = m_tgt;
                end else begin
                    q.push_back('{a: m_ptr, d: ram[m_ptr]});
                    m_ptr = m_ptr + 1'b1;
                    m_req = (q.size() < DEPTH);
                end
            end else if (!m_req) begin
                m_req = (pre < DEPTH);
            end
        end

        if (m_req && (!prev || took))
            wait_cnt = $urandom_range(lat_max, lat_min);
        else if (m_req && wait_cnt > 0)
            wait_cnt--;
        @(negedge clock);
    endtask

    initial begin
        logic found;
        n_checks = 0;
        n_bad    = 0;
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h100 + 32'(i);
        reset              = 1'b1;
        bus.flush_valid    = 1'b0;
        bus.flush_address  = '0;
        bus.out_ready      = 1'b0;
        bus.bus_read_ready = 1'b0;
        bus.bus_read_data  = '0;
        q.delete();
        m_req    = 1'b0;
        m_drain  = 1'b0;
        m_ptr    = '0;
        m_tgt    = '0;
        wait_cnt = 0;
        lat_min  = 2;
        lat_max  = 2;
        @(negedge clock);

        // Fill with the consumer stalled, then sit idle while full.
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        // Single pop frees a slot and triggers a fetch at address 4.
        step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);
        // Flush while idle and full: wraps from 0x1F to 0x00.
        step(1'b0, 1'b1, 5'h1E, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Flush while a slow read is in flight.
        lat_min = 3;
        lat_max = 3;
        found   = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_req && wait_cnt == 3) found = 1'b1;
            else step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
        check_eq("wait_pending", 64'(found), 64'h1);
        step(1'b0, 1'b1, 5'h10, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Flush coinciding with the read response.
        lat_min = 1;
        lat_max = 1;
        found   = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_req && wait_cnt == 0) found = 1'b1;
            else step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
        check_eq("wait_ready", 64'(found), 64'h1);
        step(1'b0, 1'b1, 5'h07, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b1, 1'b0);

        // Reset during a request, followed by a stray response.
        lat_min = 2;
        lat_max = 2;
        found   = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (m_req && wait_cnt > 0) found = 1'b1;
            else step(1'b0, 1'b0, '0, 1'b1, 1'b0);
        end
        check_eq("wait_req", 64'(found), 64'h1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Random traffic.
        for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
        lat_min = 0;
        lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 200) == 0, ($urandom % 25) == 0, AW'($urandom),
                 ($urandom % 2) == 0, 1'b0);
        end
        check_outputs();

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule

// File: doc/common_ram_prefetcher.md
Name: common_ram_prefetcher

Overview:
- Sequential read-ahead master directly upstream of common_ram: drives its read port and buffers fetched words in a DEPTH-entry FIFO for a downstream consumer (instruction decode).
- Fetches consecutive word addresses starting at RESET_ADDRESS or at a flush target.
- Keeps at most one read outstanding on the RAM bus.
- Never drives the RAM write port.

Parameters:
- ADDR_WIDTH, 5, RAM word-address width; matches common_ram.
- DATA_WIDTH, 32, RAM word width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_ADDRESS, 0, first fetch address after reset.

Ports:
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- bus_read_vaild  out  1  read request to common_ram.
- bus_read_ready  in  1  one-cycle pulse from common_ram; read data valid in that cycle.
- bus_read_address  out  ADDR_WIDTH  read address; stable while bus_read_vaild is high.
- bus_read_data  in  DATA_WIDTH  read data; sampled only when bus_read_ready is high.
- flush_valid  in  1  one-cycle pulse: discard buffered words, restart fetch.
- flush_address  in  ADDR_WIDTH  restart address; sampled with flush_valid.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts the head word this cycle.
- out_data  out  DATA_WIDTH  head word.
- out_address  out  ADDR_WIDTH  RAM address the head word was read from.
- out_count  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: bus_read_vaild=0, bus_read_address=RESET_ADDRESS, out_valid=0, out_count=0, out_data=0, out_address=0.
  - FIFO pointers=0, fetch pointer=RESET_ADDRESS, state=IDLE.
  - Reset asserted mid-transaction aborts everything immediately; any late bus_read_ready is ignored because the state is IDLE.
- Outputs: all registered. out_data and out_address come from the FIFO head, with out_data=0 when empty.
- States:
  - IDLE: if out_count < DEPTH, go to REQ next cycle; bus_read_vaild=1, bus_read_address=fetch pointer.
  - REQ: hold vaild and address until bus_read_ready=1. On the ready cycle:
    - push {data, address} into the FIFO;
    - fetch pointer += 1, wrapping modulo 2^ADDR_WIDTH (31 → 0);
    - if post-push occupancy (counting a same-cycle pop) < DEPTH, stay in REQ with the new address (back-to-back, vaild stays high); else go to IDLE with vaild=0.
  - DRAIN: a flush arrived while a read was in flight. Keep vaild and the old address until ready, discard that data, then go to REQ at the flush address.
- Flush handling:
  - flush_valid clears the FIFO (count=0, out_valid=0 next cycle) and loads the fetch pointer with flush_address.
  - From IDLE: go to REQ with the flush address next cycle.
  - From REQ without ready that cycle: go to DRAIN.
  - From REQ with ready in the same cycle: the arriving word is dropped and the state goes to REQ at flush_address.
  - A pop in the flush cycle is ignored; flush wins.
- Priority: reset > flush > ready/push > pop.
- FIFO:
  - Pop when out_valid && out_ready. Simultaneous push and pop leaves count unchanged.
  - Overflow is impossible by construction: a request is only issued when count < DEPTH.
  - out_ready while empty has no effect.
- Latency:
  - Reset deassert → first vaild after 1 cycle.
  - Word visible on out_valid the cycle after its bus_read_ready.
  - Flush → new-address vaild after 1 cycle (IDLE/REQ case) or 1 cycle after the in-flight ready (DRAIN case).
- No write-port outputs. bus_read_address changes only when vaild is low or on a ready cycle.

Test Plan:
1. Reset, then RAM model returns data=addr+0x100 with ready 2 cycles after each vaild; out_ready=0 → reads addresses 0,1,2,3; out_count reaches 4; vaild drops and stays 0; head out_data=0x100, out_address=0.
2. Continue scenario 1 with out_ready=1 for one cycle → head becomes 0x101/1; a new request is issued at address 4.
3. flush_valid with flush_address=0x1E while idle and full → count=0 next cycle; fetches 0x1E, 0x1F, 0x00, 0x01 (wrap); out_address sequence matches.
4. Flush to 0x10 while a read at 0x05 is pending (ready 3 cycles later) → vaild held at 0x05 until ready; word 0x105 never appears at out; next request at 0x10.
5. Flush in the same cycle as bus_read_ready → the arriving word is dropped; next vaild has address=flush_address; count=0.
6. Assert reset for one cycle during REQ, then return a stray ready → all outputs at reset values; stray data not pushed; fetch restarts at RESET_ADDRESS.
